// File: rtl/lane_loader_if.sv
// Word-in / frame-out bus of the lane loader.
// The upstream feeder and the downstream selector share this bundle.
interface lane_loader_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_lane;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [4*DATA_W-1:0] inp_out;
  logic [3:0]          valid_out;
  logic [2:0]          cnt_out;
  logic                frame_valid;
  logic                frame_ack;

  modport master (
    output in_data, in_lane, in_valid, in_last, frame_ack,
    input  in_ready, inp_out, valid_out, cnt_out, frame_valid
  );

  modport slave (
    input  in_data, in_lane, in_valid, in_last, frame_ack,
    output in_ready, inp_out, valid_out, cnt_out, frame_valid
  );
endinterface

// File: rtl/lane_loader.sv
// Packs lane-tagged words into a 4-lane frame.
// The frame closes on last, on a full mask or on an idle timeout, then waits for an ack.
module lane_loader #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  lane_loader_if.slave bus
);

  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned TMO_W = 8;
  localparam bit          TMO_EN = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                         state_q, state_d;
  logic [LANES-1:0][DATA_W-1:0]   lanes_q, lanes_d;
  logic [LANES-1:0]               mask_q, mask_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [TMO_W-1:0]               tmo_q, tmo_d;
  logic                           close;

  // Next-state and next-frame computation
  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    mask_d  = mask_q;
    tmo_d   = tmo_q;
    close   = 1'b0;
    cnt_d   = '0;

    unique case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          lanes_d[bus.in_lane] = bus.in_data;
          mask_d[bus.in_lane]  = 1'b1;
          tmo_d                = '0;
          close                = bus.in_last || (mask_d == {LANES{1'b1}});
        end else if (TMO_EN && (mask_q != '0)) begin
          // Idle edge on a non-empty frame: count towards the timeout
          if (tmo_q == TMO_LAST) begin
            close = 1'b1;
            tmo_d = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        if (close) state_d = HOLD;
      end
      HOLD: begin
        if (bus.frame_ack) begin
          state_d = FILL;
          lanes_d = '0;
          mask_d  = '0;
          tmo_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase

    for (int k = 0; k < int'(LANES); k++) begin
      cnt_d = cnt_d + CNT_W'(mask_d[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      lanes_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.in_ready    = (state_q == FILL) && !rst;
  assign bus.inp_out     = lanes_q;
  assign bus.valid_out   = mask_q;
  assign bus.cnt_out     = cnt_q;
  assign bus.frame_valid = (state_q == HOLD);

endmodule
